dma_engineer_arbiter: RTL and testbench
=======================================

// Module: dma_engineer_arbiter
// PURPOSE
//  Shares one DMA engine between NUM_CLIENTS layer controllers (conv/pool/fc); each client keeps its own
//  dma_engineer_req/ack/start_addr/length/dout_en/dout_eop handshake.
//  Round-robin arbitration; the grant is held from acceptance until the end-of-packet beat.
//  Routes engine beat strobes only to the granted client's weight double buffer.
//  Sits between the per-layer controllers and the single DDR DMA engine.
// PARAMETERS
//  NUM_CLIENTS  4    number of requesting layer controllers (2..8)
//  ADDR_W       27   width of start address and length
//  DATA_W       512  engine beat width
//  ID_W         2    width of grant_id; must satisfy 2**ID_W >= NUM_CLIENTS
// PORTS
//  clk              in   1                clock, all logic rising-edge
//  rst              in   1                synchronous, active-low reset
//  c_req            in   NUM_CLIENTS      per-client request, held until its c_ack
//  c_start_addr     in   NUM_CLIENTS*ADDR_W  client i at [i*ADDR_W +: ADDR_W]
//  c_length         in   NUM_CLIENTS*ADDR_W  client i at [i*ADDR_W +: ADDR_W]
//  c_ack            out  NUM_CLIENTS      one-cycle accept pulse to client i
//  c_dout_en        out  NUM_CLIENTS      beat valid, granted client only
//  c_dout_eop       out  NUM_CLIENTS      last beat, granted client only
//  c_dout           out  DATA_W           engine data broadcast to all clients
//  m_req            out  1                request to the DMA engine
//  m_start_addr     out  ADDR_W           latched address of granted client
//  m_length         out  ADDR_W           latched length of granted client
//  m_ack            in   1                engine accept pulse
//  m_dout_en        in   1                engine beat valid
//  m_dout_eop       in   1                engine last beat, qualified by m_dout_en
//  m_dout           in   DATA_W           engine beat data
//  busy             out  1                state != IDLE
//  grant_id         out  ID_W             index of current/last granted client
//  err_spurious     out  1                sticky: beat arrived outside XFER
// BEHAVIOUR
//  Reset values (rst==0 at a clock edge): all outputs 0; state=IDLE; rr_ptr=0.
//    Applies mid-transfer; the aborted grant is forgotten and no ack or eop is generated.
//  Round-robin: the winner is the first set c_req bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_CLIENTS.
//    At grant completion, rr_ptr := winner+1 (wraps).
//  IDLE:
//    - If any c_req, latch winner's addr/length into m_start_addr/m_length and set grant_id.
//    - Zero-length winner: c_ack[winner]=1 next cycle, m_req stays 0, rr_ptr advances, stay IDLE.
//    - Nonzero length: go to ISSUE.
//  ISSUE:
//    - m_req=1; m_start_addr/m_length held stable.
//    - On m_ack: m_req deasserts the next cycle, c_ack[grant_id]=1 for exactly that cycle, go to XFER.
//  XFER:
//    - Combinational routing: c_dout_en[grant_id]=m_dout_en and c_dout_eop[grant_id]=m_dout_en&m_dout_eop;
//      all other client bits 0.
//    - On m_dout_en&m_dout_eop: advance rr_ptr and go to IDLE.
//    - One mandatory IDLE cycle follows before the next grant.
//  m_ack outside ISSUE: ignored.
//  m_dout_en outside XFER:
//    - c_dout_en/c_dout_eop stay 0.
//    - err_spurious:=1 until reset.
//  c_dout = m_dout always (no register).
//  Client deasserts c_req while in ISSUE: the request is still completed.
//    This is a client protocol violation and is not checked.
//  Clients raising c_req during another grant wait; no request is lost.
//  Starvation bound: a held request is granted within NUM_CLIENTS-1 other grants.
//  Latency:
//    - c_req to m_req: 2 cycles.
//    - m_ack to c_ack: 1 cycle.
//    - Beat routing: 0 cycles.
// TESTING
//  1. Single client 0: addr=0x100, len=2; m_ack at cycle 5; 2 beats with eop on beat 2.
//     -> m_req high cycles 2..5; c_ack[0] pulse at cycle 6; c_dout_en[0] pulses twice;
//     c_dout_eop[0] on beat 2; busy low after.
//  2. All 4 clients request together and keep re-requesting.
//     -> grant order 0,1,2,3,0; each m_start_addr matches that client's address.
//  3. Client 2 len=0 while idle.
//     -> c_ack[2] pulse; m_req never asserts; rr_ptr becomes 3.
//  4. m_dout_en pulse while IDLE.
//     -> no c_dout_en bit set; err_spurious=1 and stays 1 until rst=0.
//  5. rst=0 during XFER beat 1 of 4, then release.
//     -> all outputs 0; state IDLE; pending c_req re-arbitrated from rr_ptr=0.
//  6. Client 1 in XFER while client 3 requests.
//     -> client 3 gets no c_dout_en during client 1's beats; client 3 is granted after one IDLE cycle.

Source files
------------

// File: rtl/dma_engineer_arbiter.sv
// Round-robin arbiter sharing one DDR DMA engine among several layer controllers.
// A grant is held from engine acceptance until the end-of-packet beat; beats route only to the granted client.
module dma_engineer_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 512,
  parameter int ID_W        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        c_req,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] c_start_addr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] c_length,
  output logic [NUM_CLIENTS-1:0]        c_ack,
  output logic [NUM_CLIENTS-1:0]        c_dout_en,
  output logic [NUM_CLIENTS-1:0]        c_dout_eop,
  output logic [DATA_W-1:0]             c_dout,
  output logic                          m_req,
  output logic [ADDR_W-1:0]             m_start_addr,
  output logic [ADDR_W-1:0]             m_length,
  input  logic                          m_ack,
  input  logic                          m_dout_en,
  input  logic                          m_dout_eop,
  input  logic [DATA_W-1:0]             m_dout,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          err_spurious
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              arb_go;
  logic              acc;
  logic              beat_last;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W-1:0] win_len;
  int                idx;

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_CLIENTS - 1) return '0;
    return id + ID_W'(1);
  endfunction

  function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_CLIENTS-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Scan from rr_ptr upward; iterating backwards lets the nearest requester win.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_CLIENTS;
      if (c_req[idx]) begin
        winner  = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign win_addr  = c_start_addr[int'(winner)*ADDR_W +: ADDR_W];
  assign win_len   = c_length[int'(winner)*ADDR_W +: ADDR_W];
  // A pending zero-length ack blocks arbitration so the still-held request is not granted twice.
  assign arb_go    = (state == IDLE) && any_req && !(|c_ack);
  assign acc       = (state == ISSUE) && m_req && m_ack;
  assign beat_last = m_dout_en && m_dout_eop;
  assign c_dout    = m_dout;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_go && (win_len != '0)) state_nxt = ISSUE;
      ISSUE:   if (acc)                       state_nxt = XFER;
      XFER:    if (beat_last)                 state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    c_dout_en  = '0;
    c_dout_eop = '0;
    if (state == XFER && m_dout_en) begin
      c_dout_en  = onehot(grant_id);
      if (m_dout_eop) c_dout_eop = onehot(grant_id);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      m_start_addr <= '0;
      m_length     <= '0;
      m_req        <= 1'b0;
      c_ack        <= '0;
      err_spurious <= 1'b0;
    end else begin
      c_ack <= '0;
      m_req <= (state == ISSUE) && !acc;
      if (arb_go) begin
        m_start_addr <= win_addr;
        m_length     <= win_len;
        grant_id     <= winner;
        if (win_len == '0) begin
          c_ack  <= onehot(winner);
          rr_ptr <= ptr_inc(winner);
        end
      end
      if (acc) c_ack <= onehot(grant_id);
      if (state == XFER && beat_last) rr_ptr <= ptr_inc(grant_id);
      if (m_dout_en && state != XFER) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_engineer_arbiter.sv
// Directed bench for dma_engineer_arbiter: latency, round-robin order, zero-length, spurious beats, reset, routing.
module tb_dma_engineer_arbiter;
  localparam int N  = 4;
  localparam int AW = 27;
  localparam int DW = 512;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    c_req = '0;
  logic [N*AW-1:0] c_start_addr = '0;
  logic [N*AW-1:0] c_length = '0;
  logic [N-1:0]    c_ack, c_dout_en, c_dout_eop;
  logic [DW-1:0]   c_dout;
  logic            m_req;
  logic [AW-1:0]   m_start_addr, m_length;
  logic            m_ack = 1'b0;
  logic            m_dout_en = 1'b0;
  logic            m_dout_eop = 1'b0;
  logic [DW-1:0]   m_dout = '0;
  logic            busy;
  logic [IW-1:0]   grant_id;
  logic            err_spurious;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dma_engineer_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .c_req(c_req), .c_start_addr(c_start_addr), .c_length(c_length),
    .c_ack(c_ack), .c_dout_en(c_dout_en), .c_dout_eop(c_dout_eop), .c_dout(c_dout),
    .m_req(m_req), .m_start_addr(m_start_addr), .m_length(m_length), .m_ack(m_ack),
    .m_dout_en(m_dout_en), .m_dout_eop(m_dout_eop), .m_dout(m_dout),
    .busy(busy), .grant_id(grant_id), .err_spurious(err_spurious)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int i, input logic [AW-1:0] a, input logic [AW-1:0] l);
    c_start_addr[i*AW +: AW] = a;
    c_length[i*AW +: AW]     = l;
  endtask

  task automatic wait_m_req();
    int n;
    n = 0;
    while (m_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_eq("m_req_up", 64'(m_req), 64'(1));
  endtask

  // Full grant for client id: accept, nbeats beats with eop on the last, then the idle gap.
  task automatic serve(input int id, input logic [AW-1:0] addr, input int nbeats, input bit drop);
    logic [N-1:0]  mask;
    logic [63:0]   pat;
    mask = N'(1) << id;
    wait_m_req();
    check_eq("grant_id", 64'(grant_id), 64'(id));
    check_eq("m_start_addr", 64'(m_start_addr), 64'(addr));
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    check_eq("c_ack", 64'(c_ack), 64'(mask));
    check_eq("m_req_drop", 64'(m_req), 64'(0));
    if (drop) c_req[id] = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      pat        = 64'hA5A5_0000_0000_0000 + 64'(b) + 64'(id) * 64'h100;
      m_dout     = {8{pat}};
      m_dout_en  = 1'b1;
      m_dout_eop = (b == nbeats - 1);
      #1;
      check_eq("c_dout_en", 64'(c_dout_en), 64'(mask));
      check_eq("c_dout_eop", 64'(c_dout_eop), (b == nbeats - 1) ? 64'(mask) : 64'(0));
      check_eq("c_dout", c_dout[DW-1 -: 64], pat);
      step();
    end
    m_dout_en  = 1'b0;
    m_dout_eop = 1'b0;
    check_eq("idle_gap", 64'(busy), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m_req"}, 64'(m_req), 64'(0));
    check_eq({tag, "_c_ack"}, 64'(c_ack), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_grant"}, 64'(grant_id), 64'(0));
    check_eq({tag, "_addr"}, 64'(m_start_addr), 64'(0));
    check_eq({tag, "_len"}, 64'(m_length), 64'(0));
    check_eq({tag, "_en"}, 64'(c_dout_en), 64'(0));
    check_eq({tag, "_eop"}, 64'(c_dout_eop), 64'(0));
    check_eq({tag, "_err"}, 64'(err_spurious), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b1;

    // 1: single client latency and two-beat transfer
    set_client(0, 27'h100, 27'd2);
    c_req = 4'b0001;
    step();
    check_eq("t1_m_req_c1", 64'(m_req), 64'(0));
    check_eq("t1_busy_c1", 64'(busy), 64'(1));
    for (int c = 2; c <= 5; c++) begin
      step();
      check_eq("t1_m_req_hi", 64'(m_req), 64'(1));
    end
    check_eq("t1_m_addr", 64'(m_start_addr), 64'(27'h100));
    check_eq("t1_m_len", 64'(m_length), 64'(2));
    m_ack = 1'b1;
    step();
    m_ack = 1'b0;
    check_eq("t1_c_ack", 64'(c_ack), 64'(4'b0001));
    check_eq("t1_m_req_lo", 64'(m_req), 64'(0));
    c_req = 4'b0000;
    step();
    check_eq("t1_c_ack_once", 64'(c_ack), 64'(0));
    m_dout_en = 1'b1; m_dout_eop = 1'b0; #1;
    check_eq("t1_en_b1", 64'(c_dout_en), 64'(4'b0001));
    check_eq("t1_eop_b1", 64'(c_dout_eop), 64'(0));
    step();
    m_dout_eop = 1'b1; #1;
    check_eq("t1_en_b2", 64'(c_dout_en), 64'(4'b0001));
    check_eq("t1_eop_b2", 64'(c_dout_eop), 64'(4'b0001));
    step();
    m_dout_en = 1'b0; m_dout_eop = 1'b0;
    check_eq("t1_busy_after", 64'(busy), 64'(0));
    check_eq("t1_err", 64'(err_spurious), 64'(0));

    // 2: all four request continuously, order 0,1,2,3,0
    rst = 1'b0; step(); rst = 1'b1;
    for (int i = 0; i < N; i++) set_client(i, 27'h1000 + 27'(i) * 27'h10, 27'd8);
    c_req = 4'b1111;
    serve(0, 27'h1000, 1, 1'b0);
    serve(1, 27'h1010, 1, 1'b0);
    serve(2, 27'h1020, 1, 1'b0);
    serve(3, 27'h1030, 1, 1'b0);
    serve(0, 27'h1000, 1, 1'b0);
    c_req = 4'b0000;
    step();

    // 3: zero-length client 2 from rr_ptr=1
    set_client(2, 27'h2000, 27'd0);
    c_req = 4'b0100;
    step();
    check_eq("t3_c_ack", 64'(c_ack), 64'(4'b0100));
    check_eq("t3_m_req", 64'(m_req), 64'(0));
    check_eq("t3_busy", 64'(busy), 64'(0));
    c_req = 4'b0000;
    step();
    check_eq("t3_c_ack_once", 64'(c_ack), 64'(0));
    check_eq("t3_m_req2", 64'(m_req), 64'(0));
    set_client(2, 27'h2000, 27'd4);
    set_client(3, 27'h3000, 27'd4);
    c_req = 4'b1100;
    serve(3, 27'h3000, 1, 1'b1);
    serve(2, 27'h2000, 1, 1'b1);

    // 4: spurious beat while idle
    m_dout_en = 1'b1; m_dout_eop = 1'b1; #1;
    check_eq("t4_en", 64'(c_dout_en), 64'(0));
    check_eq("t4_eop", 64'(c_dout_eop), 64'(0));
    step();
    m_dout_en = 1'b0; m_dout_eop = 1'b0;
    check_eq("t4_err", 64'(err_spurious), 64'(1));
    step(); step();
    check_eq("t4_err_sticky", 64'(err_spurious), 64'(1));
    rst = 1'b0; step(); rst = 1'b1;
    check_eq("t4_err_clr", 64'(err_spurious), 64'(0));

    // 5: reset during beat 1 of 4, pending requests re-arbitrated from 0
    set_client(1, 27'h1100, 27'd2);
    c_req = 4'b0010;
    serve(1, 27'h1100, 2, 1'b1);
    set_client(2, 27'h2200, 27'd4);
    set_client(3, 27'h3300, 27'd4);
    c_req = 4'b0100;
    wait_m_req();
    check_eq("t5_grant", 64'(grant_id), 64'(2));
    m_ack = 1'b1; step(); m_ack = 1'b0;
    c_req = 4'b1010;
    m_dout_en = 1'b1; m_dout_eop = 1'b0; #1;
    check_eq("t5_en_b1", 64'(c_dout_en), 64'(4'b0100));
    rst = 1'b0;
    step();
    m_dout_en = 1'b0;
    check_reset_outputs("t5");
    rst = 1'b1;
    serve(1, 27'h1100, 1, 1'b1);
    serve(3, 27'h3300, 1, 1'b1);

    // 6: client 3 waits through client 1's beats, then gets the next grant
    c_req = 4'b0010;
    wait_m_req();
    check_eq("t6_grant1", 64'(grant_id), 64'(1));
    m_ack = 1'b1; step(); m_ack = 1'b0;
    c_req = 4'b1000;
    for (int b = 0; b < 3; b++) begin
      m_dout_en = 1'b1; m_dout_eop = (b == 2); #1;
      check_eq("t6_en", 64'(c_dout_en), 64'(4'b0010));
      step();
    end
    m_dout_en = 1'b0; m_dout_eop = 1'b0;
    check_eq("t6_idle_busy", 64'(busy), 64'(0));
    check_eq("t6_idle_en", 64'(c_dout_en), 64'(0));
    step();
    check_eq("t6_busy3", 64'(busy), 64'(1));
    check_eq("t6_grant3", 64'(grant_id), 64'(3));
    serve(3, 27'h3300, 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
